// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: unit/op enums, opcode and funct constants, immediate formats.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {UnitAlu, UnitBranch, UnitLsu, UnitMul} unit_t;

  typedef enum logic [5:0] {
    OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
    OpLui, OpAuipc, OpNop, OpJal, OpJalr,
    OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
    OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw,
    OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
  } op_t;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SR  = 3'd5;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  function automatic logic [31:0] imm_gen(input logic [31:7] ib, input imm_fmt_t fmt);
    case (fmt)
      ImmI:    return {{21{ib[31]}}, ib[30:20]};
      ImmS:    return {{21{ib[31]}}, ib[30:25], ib[11:7]};
      ImmB:    return {{20{ib[31]}}, ib[7], ib[30:25], ib[11:8], 1'b0};
      ImmU:    return {ib[31:12], 12'b0};
      ImmJ:    return {{12{ib[31]}}, ib[19:12], ib[20], ib[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  function automatic op_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? OpSub : OpAdd;
      3'd1:    return OpSll;
      3'd2:    return OpSlt;
      3'd3:    return OpSltu;
      3'd4:    return OpXor;
      3'd5:    return alt ? OpSra : OpSrl;
      3'd6:    return OpOr;
      default: return OpAnd;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode, writeback and decode-to-EXE signal bundle.
interface decode_if import riscv_pkg::*; #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) ();
  logic [31:0]     instr_q_i;
  logic [XLEN-1:0] pc_q_i;
  logic            flush_v_i;
  logic            wb_en_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            exe_valid_q_o;
  logic [XLEN-1:0] pc_q_o;
  logic [XLEN-1:0] rs1_data_q_o;
  logic [XLEN-1:0] rs2_data_q_o;
  logic [XLEN-1:0] imm_q_o;
  logic [4:0]      rd_q_o;
  logic            rd_wen_q_o;
  unit_t           unit_q_o;
  op_t             op_q_o;
  logic            illegal_q_o;

  modport master (
    output instr_q_i, pc_q_i, flush_v_i, wb_en_i, wb_rd_i, wb_data_i,
    input  exe_valid_q_o, pc_q_o, rs1_data_q_o, rs2_data_q_o, imm_q_o, rd_q_o, rd_wen_q_o,
           unit_q_o, op_q_o, illegal_q_o
  );

  modport slave (
    input  instr_q_i, pc_q_i, flush_v_i, wb_en_i, wb_rd_i, wb_data_i,
    output exe_valid_q_o, pc_q_o, rs1_data_q_o, rs2_data_q_o, imm_q_o, rd_q_o, rd_wen_q_o,
           unit_q_o, op_q_o, illegal_q_o
  );
endinterface

// File: rtl/decode_regfile.sv
// 32 x XLEN register file, 2 async reads, 1 sync write, x0 hardwired, write-to-read bypass.
module decode_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] mem_q [32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end
endmodule

// File: rtl/decode.sv
// RV32I decode stage with squash FSM and registered micro-op output.
// Define DECODE_M_EXT_EN to decode the RV32M ops onto the MUL unit.
module decode import riscv_pkg::*; #(
  parameter int unsigned XLEN         = riscv_pkg::XLEN,
  parameter bit          RESET_SQUASH = 1'b1
) (
  input logic    clk,
  input logic    reset_n,
  decode_if.slave bus
);
  typedef enum logic {StSquash, StRun} state_e;
  localparam state_e StReset = RESET_SQUASH ? StSquash : StRun;

  state_e state_q, state_d;
  logic   in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StReset;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = StRun;
    in_valid = (state_q == StRun) & ~bus.flush_v_i;
  end

  logic [31:0] instr;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  unit_t       unit_d;
  op_t         op_d;
  imm_fmt_t    fmt;
  logic        wen_d, illegal_d;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign instr = bus.instr_q_i;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rd    = instr[11:7];

  always_comb begin
    unit_d    = UnitAlu;
    op_d      = OpNop;
    fmt       = ImmNone;
    wen_d     = 1'b0;
    illegal_d = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end else begin
      case (opc)
        OPC_LUI:   begin op_d = OpLui;   fmt = ImmU; wen_d = 1'b1; end
        OPC_AUIPC: begin op_d = OpAuipc; fmt = ImmU; wen_d = 1'b1; end
        OPC_JAL: begin
          unit_d = UnitBranch; op_d = OpJal; fmt = ImmJ; wen_d = 1'b1;
        end
        OPC_JALR: begin
          unit_d = UnitBranch; op_d = OpJalr; fmt = ImmI; wen_d = 1'b1;
          illegal_d = (f3 != 3'd0);
        end
        OPC_BRANCH: begin
          unit_d = UnitBranch; fmt = ImmB;
          case (f3)
            3'd0:    op_d = OpBeq;
            3'd1:    op_d = OpBne;
            3'd4:    op_d = OpBlt;
            3'd5:    op_d = OpBge;
            3'd6:    op_d = OpBltu;
            3'd7:    op_d = OpBgeu;
            default: illegal_d = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          unit_d = UnitLsu; fmt = ImmI; wen_d = 1'b1;
          case (f3)
            3'd0:    op_d = OpLb;
            3'd1:    op_d = OpLh;
            3'd2:    op_d = OpLw;
            3'd4:    op_d = OpLbu;
            3'd5:    op_d = OpLhu;
            default: illegal_d = 1'b1;
          endcase
        end
        OPC_STORE: begin
          unit_d = UnitLsu; fmt = ImmS;
          case (f3)
            3'd0:    op_d = OpSb;
            3'd1:    op_d = OpSh;
            3'd2:    op_d = OpSw;
            default: illegal_d = 1'b1;
          endcase
        end
        OPC_OP_IMM: begin
          fmt   = ImmI;
          wen_d = 1'b1;
          // Only the shift-immediates constrain the funct7 field.
          op_d  = alu_op(f3, instr[30] & (f3 == F3_SR));
          if (f3 == F3_SLL) illegal_d = (f7 != F7_BASE);
          if (f3 == F3_SR)  illegal_d = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
        OPC_OP: begin
          wen_d = 1'b1;
          if (f7 == F7_BASE) begin
            op_d = alu_op(f3, 1'b0);
          end else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) begin
            op_d = alu_op(f3, 1'b1);
`ifdef DECODE_M_EXT_EN
          end else if (f7 == F7_MULDIV) begin
            unit_d = UnitMul;
            op_d   = op_t'(6'(OpMul) + 6'(f3));
`endif
          end else begin
            illegal_d = 1'b1;
          end
        end
        OPC_MISC_MEM: begin fmt = ImmI; illegal_d = (f3 != 3'd0); end
        default:      illegal_d = 1'b1;
      endcase
    end
    wen_d = wen_d & ~illegal_d & (rd != 5'd0);
  end

  decode_regfile #(.XLEN(XLEN)) u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (bus.wb_en_i),
    .waddr  (bus.wb_rd_i),
    .wdata  (bus.wb_data_i)
  );

  logic            valid_q, rd_wen_q, illegal_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [4:0]      rd_q;
  unit_t           unit_q;
  op_t             op_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      rd_wen_q  <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      unit_q    <= unit_t'('0);
      op_q      <= op_t'('0);
    end else begin
      valid_q   <= in_valid;
      rd_wen_q  <= in_valid & wen_d;
      illegal_q <= in_valid & illegal_d;
      pc_q      <= bus.pc_q_i;
      rs1_q     <= rs1_data;
      rs2_q     <= rs2_data;
      imm_q     <= XLEN'($signed(imm_gen(instr[31:7], fmt)));
      rd_q      <= rd;
      unit_q    <= unit_d;
      op_q      <= op_d;
    end
  end

  assign bus.exe_valid_q_o = valid_q;
  assign bus.rd_wen_q_o    = rd_wen_q;
  assign bus.illegal_q_o   = illegal_q;
  assign bus.pc_q_o        = pc_q;
  assign bus.rs1_data_q_o  = rs1_q;
  assign bus.rs2_data_q_o  = rs2_q;
  assign bus.imm_q_o       = imm_q;
  assign bus.rd_q_o        = rd_q;
  assign bus.unit_q_o      = unit_q;
  assign bus.op_q_o        = op_q;
endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: randomized instructions against a behavioural RV32I model.
module tb_decode;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  decode_if #(.XLEN(32)) bus ();
  decode dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] pc_ctr = 32'h1000;

  typedef struct packed {
    logic        valid, illegal, wen, has_imm;
    logic [4:0]  rd;
    unit_t       unit;
    op_t         op;
    logic [31:0] imm, pc, a, b;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RV32I decode, written from the ISA tables.
  function automatic exp_t golden(input logic [31:0] w, input logic [31:0] pc, input logic iv,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit legal, writes, m_en;
    op_t alu_tbl [8];
    op_t br_tbl [8];
    op_t ld_tbl [8];
    op_t st_tbl [8];
    op_t mul_tbl [8];
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    alu_tbl = '{OpAdd, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpOr, OpAnd};
    br_tbl  = '{OpBeq, OpBne, OpNop, OpNop, OpBlt, OpBge, OpBltu, OpBgeu};
    ld_tbl  = '{OpLb, OpLh, OpLw, OpNop, OpLbu, OpLhu, OpNop, OpNop};
    st_tbl  = '{OpSb, OpSh, OpSw, OpNop, OpNop, OpNop, OpNop, OpNop};
    mul_tbl = '{OpMul, OpMulh, OpMulhsu, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
`ifdef DECODE_M_EXT_EN
    m_en = 1;
`else
    m_en = 0;
`endif
    e = '0;
    e.valid = iv; e.pc = pc; e.a = a; e.b = b;
    if (!iv) return e;
    f3 = w[14:12]; f7 = w[31:25]; e.rd = w[11:7];
    imm_i = {{20{w[31]}}, w[31:20]};
    imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_u = {w[31:12], 12'h000};
    imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    legal = 0; writes = 0; e.unit = UnitAlu; e.op = OpNop; e.has_imm = 1;
    case (w[6:0])
      7'h37: begin legal = 1; writes = 1; e.op = OpLui; e.imm = imm_u; end
      7'h17: begin legal = 1; writes = 1; e.op = OpAuipc; e.imm = imm_u; end
      7'h6F: begin legal = 1; writes = 1; e.unit = UnitBranch; e.op = OpJal; e.imm = imm_j; end
      7'h67: begin
        legal = (f3 == 0); writes = 1; e.unit = UnitBranch; e.op = OpJalr; e.imm = imm_i;
      end
      7'h63: begin
        legal = !(f3 inside {2, 3}); e.unit = UnitBranch; e.op = br_tbl[f3]; e.imm = imm_b;
      end
      7'h03: begin
        legal = f3 inside {0, 1, 2, 4, 5}; writes = 1; e.unit = UnitLsu; e.op = ld_tbl[f3];
        e.imm = imm_i;
      end
      7'h23: begin legal = f3 <= 2; e.unit = UnitLsu; e.op = st_tbl[f3]; e.imm = imm_s; end
      7'h13: begin
        writes = 1; e.imm = imm_i; e.op = alu_tbl[f3]; legal = 1;
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin
          legal = (f7 == 0) || (f7 == 7'h20);
          if (f7 == 7'h20) e.op = OpSra;
        end
      end
      7'h33: begin
        writes = 1; e.has_imm = 0;
        if (f7 == 0) begin legal = 1; e.op = alu_tbl[f3]; end
        else if (f7 == 7'h20 && f3 == 0) begin legal = 1; e.op = OpSub; end
        else if (f7 == 7'h20 && f3 == 5) begin legal = 1; e.op = OpSra; end
        else if (f7 == 7'h01 && m_en) begin legal = 1; e.unit = UnitMul; e.op = mul_tbl[f3]; end
      end
      7'h0F: begin legal = (f3 == 0); e.op = OpNop; e.has_imm = 0; end
      default: legal = 0;
    endcase
    e.illegal = !legal;
    e.wen = legal && writes && (e.rd != 0);
    return e;
  endfunction

  // Reference register file and per-cycle comparison.
  logic [31:0] mrf [32];
  int edges = 0;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.wb_en_i && bus.wb_rd_i == idx) return bus.wb_data_i;
    return mrf[idx];
  endfunction

  always @(posedge clk) begin : cmp
    exp_t e;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
      edges = 0;
    end else begin
      e = golden(bus.instr_q_i, bus.pc_q_i, (edges > 0) && !bus.flush_v_i,
                 mread(bus.instr_q_i[19:15]), mread(bus.instr_q_i[24:20]));
      if (bus.wb_en_i && bus.wb_rd_i != 0) mrf[bus.wb_rd_i] = bus.wb_data_i;
      edges++;
      #1;
      if (reset_n) begin
        chk("valid", 32'(bus.exe_valid_q_o), 32'(e.valid));
        chk("rd_wen", 32'(bus.rd_wen_q_o), 32'(e.wen));
        chk("illegal", 32'(bus.illegal_q_o), 32'(e.illegal));
        if (e.valid) begin
          chk("pc", bus.pc_q_o, e.pc);
          chk("rs1_data", bus.rs1_data_q_o, e.a);
          chk("rs2_data", bus.rs2_data_q_o, e.b);
          if (!e.illegal) begin
            chk("unit", 32'(bus.unit_q_o), 32'(e.unit));
            chk("op", 32'(bus.op_q_o), 32'(e.op));
            if (e.has_imm) chk("imm", bus.imm_q_o, e.imm);
            if (e.wen) chk("rd", 32'(bus.rd_q_o), 32'(e.rd));
          end
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input bit fl, input bit we,
                       input logic [4:0] wr, input logic [31:0] wd);
    bus.instr_q_i = ins;
    bus.pc_q_i    = pc_ctr;
    pc_ctr        = pc_ctr + 4;
    bus.flush_v_i = fl;
    bus.wb_en_i   = we;
    bus.wb_rd_i   = wr;
    bus.wb_data_i = wd;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] opcs [11];
    int r;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    r = $urandom_range(0, 11);
    if (r < 11) w[6:0] = opcs[r];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  initial begin : main
    exp_t m;
    reset_n = 1'b1;
    bus.instr_q_i = '0; bus.pc_q_i = '0; bus.flush_v_i = 0;
    bus.wb_en_i = 0; bus.wb_rd_i = '0; bus.wb_data_i = '0;
    #1 reset_n = 1'b0;

    // Pin the model against hand-decoded encodings.
    m = golden(32'h00500093, 32'h0, 1'b1, 32'h0, 32'h0);
    chk("model_addi_imm", m.imm, 32'd5);
    chk("model_addi_op", 32'(m.op), 32'(OpAdd));
    chk("model_addi_wen", 32'(m.wen), 32'd1);
    m = golden(32'hFFDFF06F, 32'h0, 1'b1, 32'h0, 32'h0);
    chk("model_jal_imm", m.imm, 32'hFFFFFFFC);
    chk("model_jal_wen", 32'(m.wen), 32'd0);
    m = golden(32'h00000000, 32'h0, 1'b1, 32'h0, 32'h0);
    chk("model_zero_illegal", 32'(m.illegal), 32'd1);

    #11;
    chk("reset_valid", 32'(bus.exe_valid_q_o), 32'd0);
    chk("reset_imm", bus.imm_q_o, 32'd0);
    chk("reset_rs1", bus.rs1_data_q_o, 32'd0);
    chk("reset_pc", bus.pc_q_o, 32'd0);
    chk("reset_rd_wen", 32'(bus.rd_wen_q_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h00000000, 0, 0, 5'd0, 32'h0);
    chk("squash_valid", 32'(bus.exe_valid_q_o), 32'd0);
    drive(32'h00500093, 0, 0, 5'd0, 32'h0);
    chk("addi_valid", 32'(bus.exe_valid_q_o), 32'd1);
    chk("addi_unit", 32'(bus.unit_q_o), 32'(UnitAlu));
    chk("addi_rd", 32'(bus.rd_q_o), 32'd1);
    chk("addi_rd_wen", 32'(bus.rd_wen_q_o), 32'd1);
    chk("addi_imm", bus.imm_q_o, 32'd5);
    chk("addi_rs1", bus.rs1_data_q_o, 32'd0);
    drive(32'h00500093, 1, 0, 5'd0, 32'h0);
    chk("flush_valid", 32'(bus.exe_valid_q_o), 32'd0);
    drive(32'h00500093, 0, 0, 5'd0, 32'h0);
    chk("post_flush_valid", 32'(bus.exe_valid_q_o), 32'd1);
    drive(32'h00018233, 0, 1, 5'd3, 32'hDEADBEEF);
    chk("bypass_rs1", bus.rs1_data_q_o, 32'hDEADBEEF);
    drive(32'h00018233, 0, 0, 5'd0, 32'h0);
    chk("stored_rs1", bus.rs1_data_q_o, 32'hDEADBEEF);
    drive(32'h00000013, 0, 1, 5'd0, 32'h12345678);
    drive(32'h000002B3, 0, 0, 5'd0, 32'h0);
    chk("x0_rs1", bus.rs1_data_q_o, 32'd0);
    chk("x0_rs2", bus.rs2_data_q_o, 32'd0);
    drive(32'hFFDFF06F, 0, 0, 5'd0, 32'h0);
    chk("jal_imm", bus.imm_q_o, 32'hFFFFFFFC);
    chk("jal_rd_wen", 32'(bus.rd_wen_q_o), 32'd0);
    drive(32'h00000000, 0, 0, 5'd0, 32'h0);
    chk("zero_valid", 32'(bus.exe_valid_q_o), 32'd1);
    chk("zero_illegal", 32'(bus.illegal_q_o), 32'd1);
    chk("zero_rd_wen", 32'(bus.rd_wen_q_o), 32'd0);
    drive(32'h00002063, 0, 0, 5'd0, 32'h0);
    chk("beq_f3_2_illegal", 32'(bus.illegal_q_o), 32'd1);
    drive(32'h027302B3, 0, 0, 5'd0, 32'h0);
`ifdef DECODE_M_EXT_EN
    chk("mul_unit", 32'(bus.unit_q_o), 32'(UnitMul));
    chk("mul_op", 32'(bus.op_q_o), 32'(OpMul));
    chk("mul_rd", 32'(bus.rd_q_o), 32'd5);
    chk("mul_rd_wen", 32'(bus.rd_wen_q_o), 32'd1);
`else
    chk("mul_illegal", 32'(bus.illegal_q_o), 32'd1);
    chk("mul_rd_wen", 32'(bus.rd_wen_q_o), 32'd0);
`endif

    for (int i = 0; i < 2000; i++)
      drive(rand_instr(), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            5'($urandom), $urandom);

    // Asynchronous reset in mid-operation clears the register file.
    drive(32'h00000013, 0, 1, 5'd3, 32'hCAFEF00D);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(bus.exe_valid_q_o), 32'd0);
    chk("midreset_rs1", bus.rs1_data_q_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h00018233, 0, 0, 5'd0, 32'h0);
    chk("midreset_squash", 32'(bus.exe_valid_q_o), 32'd0);
    drive(32'h00018233, 0, 0, 5'd0, 32'h0);
    chk("midreset_run", 32'(bus.exe_valid_q_o), 32'd1);
    chk("midreset_x3", bus.rs1_data_q_o, 32'd0);

    for (int i = 0; i < 500; i++)
      drive(rand_instr(), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            5'($urandom), $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
